// File: rtl/mult_arbiter.sv
// mult_arbiter
// Round-robin scheduler that shares one multiplier between NUM_REQ requesters.
// Each accepted operand pair is driven to the multiplier, the enable/done
// handshake is walked (raise enable, wait done, drop enable, wait done low),
// and the product is returned with a one-hot response pulse. A watchdog
// aborts a transaction that sits in ISSUE for TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/a/b       per-requester request and packed operands
//   req_ready           one-hot combinational accept (IDLE only)
//   rsp_valid           one-hot, one-cycle response pulse (registered)
//   rsp_data/rsp_error  product / timeout flag, qualified by rsp_valid
//   busy                high whenever the arbiter is not IDLE
//   mult_*              multiplier operand, enable, done and result signals
module mult_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IN_WIDTH       = 4,
    parameter int OUT_WIDTH      = IN_WIDTH * 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*IN_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*IN_WIDTH-1:0]  req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [OUT_WIDTH-1:0]         rsp_data,
    output logic                         rsp_error,
    output logic                         busy,
    output logic [IN_WIDTH-1:0]          mult_multiplicand,
    output logic [IN_WIDTH-1:0]          mult_multiplier,
    output logic                         mult_enable,
    input  logic                         mult_done,
    input  logic [OUT_WIDTH-1:0]         mult_result
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W = ID_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] NUM_REQ_IDX = IDX_W'(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Registered state
    state_t                 state_r;
    logic [ID_W-1:0]        rr_ptr_r;
    logic [ID_W-1:0]        grant_id_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [IN_WIDTH-1:0]    op_a_r;
    logic [IN_WIDTH-1:0]    op_b_r;
    logic                   mult_enable_r;
    logic [NUM_REQ-1:0]     rsp_valid_r;
    logic [OUT_WIDTH-1:0]   rsp_data_r;
    logic                   rsp_error_r;
    logic                   busy_r;

    // Next-state values
    state_t                 state_s;
    logic [ID_W-1:0]        rr_ptr_s;
    logic [ID_W-1:0]        grant_id_s;
    logic [CNT_W-1:0]       cnt_s;
    logic [IN_WIDTH-1:0]    op_a_s;
    logic [IN_WIDTH-1:0]    op_b_s;
    logic                   mult_enable_s;
    logic [NUM_REQ-1:0]     rsp_valid_s;
    logic [OUT_WIDTH-1:0]   rsp_data_s;
    logic                   rsp_error_s;
    logic [NUM_REQ-1:0]     req_ready_s;

    // Arbitration results
    logic                   grant_found_s;
    logic [ID_W-1:0]        grant_idx_s;
    logic [IDX_W-1:0]       scan_idx_s;

    // Requester index to one-hot vector.
    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] vec;
        vec     = '0;
        vec[id] = 1'b1;
        return vec;
    endfunction

    // (id + 1) mod NUM_REQ without a divider.
    function automatic logic [ID_W-1:0] next_index(input logic [ID_W-1:0] id);
        logic [IDX_W-1:0] sum;
        sum = {1'b0, id} + IDX_W'(1);
        sum = (sum >= NUM_REQ_IDX) ? (sum - NUM_REQ_IDX) : sum;
        return sum[ID_W-1:0];
    endfunction

    // Round-robin scan starting at rr_ptr; the first valid requester wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        scan_idx_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx_s = {1'b0, rr_ptr_r} + IDX_W'(i);
            scan_idx_s = (scan_idx_s >= NUM_REQ_IDX) ? (scan_idx_s - NUM_REQ_IDX) : scan_idx_s;
            if (!grant_found_s && req_valid[scan_idx_s[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = scan_idx_s[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Next-state and datapath update for the IDLE/ISSUE/RELEASE sequence.
    always_comb begin
        state_s       = state_r;
        rr_ptr_s      = rr_ptr_r;
        grant_id_s    = grant_id_r;
        cnt_s         = cnt_r;
        op_a_s        = op_a_r;
        op_b_s        = op_b_r;
        mult_enable_s = mult_enable_r;
        rsp_valid_s   = '0;
        rsp_data_s    = rsp_data_r;
        rsp_error_s   = rsp_error_r;
        req_ready_s   = '0;

        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    req_ready_s   = to_onehot(grant_idx_s);
                    op_a_s        = req_a[int'(grant_idx_s) * IN_WIDTH +: IN_WIDTH];
                    op_b_s        = req_b[int'(grant_idx_s) * IN_WIDTH +: IN_WIDTH];
                    grant_id_s    = grant_idx_s;
                    rr_ptr_s      = next_index(grant_idx_s);
                    mult_enable_s = 1'b1;
                    cnt_s         = '0;
                    state_s       = ST_ISSUE;
                end else begin
                    mult_enable_s = 1'b0;
                    state_s       = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                mult_enable_s = 1'b1;
                cnt_s         = cnt_r + CNT_W'(1);
                // Done wins over the watchdog when both hit in the same cycle.
                if (mult_done) begin
                    rsp_data_s    = mult_result;
                    rsp_error_s   = 1'b0;
                    rsp_valid_s   = to_onehot(grant_id_r);
                    mult_enable_s = 1'b0;
                    state_s       = ST_RELEASE;
                end else if (cnt_r == CNT_LAST) begin
                    rsp_data_s    = '0;
                    rsp_error_s   = 1'b1;
                    rsp_valid_s   = to_onehot(grant_id_r);
                    mult_enable_s = 1'b0;
                    state_s       = ST_RELEASE;
                end else begin
                    state_s       = ST_ISSUE;
                end
            end
            ST_RELEASE: begin
                // Hold off the next enable until the multiplier has dropped done.
                mult_enable_s = 1'b0;
                if (mult_done) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                mult_enable_s = 1'b0;
                state_s       = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= '0;
            grant_id_r    <= '0;
            cnt_r         <= '0;
            op_a_r        <= '0;
            op_b_r        <= '0;
            mult_enable_r <= 1'b0;
            rsp_valid_r   <= '0;
            rsp_data_r    <= '0;
            rsp_error_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            rr_ptr_r      <= rr_ptr_s;
            grant_id_r    <= grant_id_s;
            cnt_r         <= cnt_s;
            op_a_r        <= op_a_s;
            op_b_r        <= op_b_s;
            mult_enable_r <= mult_enable_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_data_r    <= rsp_data_s;
            rsp_error_r   <= rsp_error_s;
            busy_r        <= (state_s != ST_IDLE);
        end
    end

    assign req_ready         = req_ready_s;
    assign rsp_valid         = rsp_valid_r;
    assign rsp_data          = rsp_data_r;
    assign rsp_error         = rsp_error_r;
    assign busy              = busy_r;
    assign mult_multiplicand = op_a_r;
    assign mult_multiplier   = op_b_r;
    assign mult_enable       = mult_enable_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter: behavioural multiplier, requester drivers,
// an accept-side process that predicts grants and pushes expected responses,
// and a response monitor that pops and compares.
module tb_mult_arbiter;

    localparam int N       = 4;
    localparam int IW      = 4;
    localparam int OW      = 8;
    localparam int TO      = 16;
    localparam int NOM_LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [IW-1:0] a_v [N];
    logic [IW-1:0] b_v [N];
    logic [N*IW-1:0] req_a;
    logic [N*IW-1:0] req_b;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [OW-1:0] rsp_data;
    logic          rsp_error;
    logic          busy;
    logic [IW-1:0] mult_multiplicand;
    logic [IW-1:0] mult_multiplier;
    logic          mult_enable;
    logic          mult_done;
    logic [OW-1:0] mult_result;

    mult_arbiter #(.NUM_REQ(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy),
        .mult_multiplicand(mult_multiplicand), .mult_multiplier(mult_multiplier),
        .mult_enable(mult_enable), .mult_done(mult_done), .mult_result(mult_result)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_a[k*IW +: IW] = a_v[k];
            req_b[k*IW +: IW] = b_v[k];
        end
    end

    // ---------------- multiplier model ----------------
    // Registers enable, samples operands one edge later, raises done one edge
    // after that; clears done on the edge it sees enable low (optionally late).
    logic          stuck = 1'b0;
    int            slow_extra = 0;
    int            hold_cnt = 0;
    logic          en_q;
    int            phase;
    logic [OW-1:0] prod;

    always @(posedge clk) begin
        if (rst) begin
            en_q <= 1'b0; phase <= 0; mult_done <= 1'b0; hold_cnt <= 0; prod <= '0;
        end else if (!mult_enable) begin
            en_q  <= 1'b0;
            phase <= 0;
            if (mult_done && hold_cnt < slow_extra) hold_cnt <= hold_cnt + 1;
            else begin mult_done <= 1'b0; hold_cnt <= 0; end
        end else begin
            en_q <= 1'b1;
            if (en_q) begin
                if (phase == 0) begin
                    prod  <= OW'(mult_multiplicand) * OW'(mult_multiplier);
                    phase <= 1;
                end else if (phase == 1) begin
                    if (!stuck) mult_done <= 1'b1;
                    phase <= 2;
                end
            end
        end
    end
    assign mult_result = prod;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; int data; int err; int acc_edge; } exp_t;
    typedef struct { int k; int a; int b; } op_t;
    exp_t exp_q[$];
    op_t  pend[$];
    int   acc_ids[$];
    int   acc_edges[$];
    int   m_ptr = 0;
    logic [N-1:0] acc_mask = '0;
    bit   rand_mode = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbiter: round-robin over requesters using the model pointer;
    // each accept pushes the response that the product rule predicts.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int gid;
        int idx;
        exp_t e;
        if (rst) begin
            m_ptr = 0;
            exp_q.delete();
            acc_mask = '0;
        end else begin
            exp_rdy = '0;
            gid = -1;
            if (!busy) begin
                for (int i = 0; i < N; i++) begin
                    idx = (m_ptr + i) % N;
                    if (gid < 0 && req_valid[idx]) gid = idx;
                end
            end
            if (gid >= 0) exp_rdy[gid] = 1'b1;
            check("req_ready", int'(req_ready), int'(exp_rdy));
            acc_mask = exp_rdy;
            if (gid >= 0) begin
                e.id       = gid;
                e.err      = int'(stuck);
                e.data     = stuck ? 0 : int'(a_v[gid]) * int'(b_v[gid]);
                e.acc_edge = cyc + 1;
                exp_q.push_back(e);
                acc_ids.push_back(gid);
                acc_edges.push_back(cyc + 1);
                m_ptr = (gid + 1) % N;
            end
        end
    end

    // Response monitor: pops the oldest expectation whenever rsp_valid is set.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid !== '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", int'(rsp_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_valid", int'(rsp_valid), 1 << e.id);
                check("rsp_data", int'(rsp_data), e.data);
                check("rsp_error", int'(rsp_error), e.err);
                check("rsp_latency", cyc - e.acc_edge, e.err ? TO : NOM_LAT);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        bit found;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_mask;
        if (rand_mode) begin
            for (int k = 0; k < N; k++) begin
                found = 1'b0;
                foreach (pend[j]) if (pend[j].k == k) found = 1'b1;
                if (req_valid[k] && $urandom_range(0, 19) == 0) req_valid[k] = 1'b0;
                else if (!req_valid[k] && !found && $urandom_range(0, 3) == 0)
                    pend.push_back('{k, int'($urandom_range(0, 15)), int'($urandom_range(0, 15))});
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!req_valid[k]) begin
                found = 1'b0;
                for (int j = 0; j < pend.size(); j++) begin
                    if (!found && pend[j].k == k) begin
                        a_v[k] = IW'(pend[j].a);
                        b_v[k] = IW'(pend[j].b);
                        req_valid[k] = 1'b1;
                        pend.delete(j);
                        found = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((pend.size() != 0 || req_valid != '0 || exp_q.size() != 0 || busy) && n < budget);
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: waited=%0d cycles, pending responses=%0d", name, n, exp_q.size());
        end
    endtask

    task automatic reset_dut();
        req_valid = '0;
        pend.delete();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        acc_ids.delete();
        acc_edges.delete();
    endtask

    initial begin
        int n;
        int exp_order[5];
        for (int k = 0; k < N; k++) begin a_v[k] = '0; b_v[k] = '0; end

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_enable", int'(mult_enable), 0);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_data", int'(rsp_data), 0);
        check("reset_rsp_error", int'(rsp_error), 0);
        check("reset_operand_a", int'(mult_multiplicand), 0);
        check("reset_operand_b", int'(mult_multiplier), 0);
        tick();
        rst = 1'b0;

        // Single request on requester 2
        clear_logs();
        pend.push_back('{2, 7, 9});
        wait_idle("single", 200);
        check("single_count", acc_ids.size(), 1);
        if (acc_ids.size() > 0) check("single_id", acc_ids[0], 2);

        // Boundary operands, back-to-back on requester 0
        clear_logs();
        pend.push_back('{0, 15, 15});
        pend.push_back('{0, 0, 13});
        pend.push_back('{0, 1, 15});
        wait_idle("boundary", 300);
        check("boundary_count", acc_edges.size(), 3);
        if (acc_edges.size() >= 3) begin
            check("issue_interval_1", acc_edges[1] - acc_edges[0], 7);
            check("issue_interval_2", acc_edges[2] - acc_edges[1], 7);
        end

        // All four requesters valid after reset
        reset_dut();
        clear_logs();
        for (int k = 0; k < N; k++) pend.push_back('{k, k + 1, 3});
        pend.push_back('{0, 1, 3});
        wait_idle("all_four", 400);
        exp_order = '{0, 1, 2, 3, 0};
        check("rr_count", acc_ids.size(), 5);
        for (int i = 0; i < 5; i++) if (i < acc_ids.size()) check("rr_order", acc_ids[i], exp_order[i]);

        // Stuck multiplier -> timeout response
        stuck = 1'b1;
        clear_logs();
        pend.push_back('{1, 5, 5});
        wait_idle("stuck", 400);
        check("stuck_count", acc_ids.size(), 1);
        stuck = 1'b0;

        // Reset two cycles after accept
        clear_logs();
        pend.push_back('{1, 2, 3});
        n = 0;
        while (acc_ids.size() == 0 && n < 50) begin tick(); n++; end
        check("reset_mid_accepted", acc_ids.size(), 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_mid_enable", int'(mult_enable), 0);
        check("reset_mid_busy", int'(busy), 0);
        check("reset_mid_rsp_valid", int'(rsp_valid), 0);
        clear_logs();
        pend.push_back('{1, 6, 7});
        pend.push_back('{3, 5, 9});
        wait_idle("after_reset", 300);
        check("after_reset_count", acc_ids.size(), 2);
        if (acc_ids.size() >= 2) begin
            check("after_reset_first", acc_ids[0], 1);
            check("after_reset_second", acc_ids[1], 3);
        end

        // Slow done clear holds the arbiter in RELEASE
        slow_extra = 3;
        clear_logs();
        pend.push_back('{2, 3, 4});
        pend.push_back('{2, 5, 6});
        wait_idle("slow_clear", 300);
        check("slow_count", acc_edges.size(), 2);
        if (acc_edges.size() >= 2) check("slow_interval", acc_edges[1] - acc_edges[0], 10);
        slow_extra = 0;

        // Randomized traffic
        reset_dut();
        rand_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) slow_extra = int'($urandom_range(0, 2));
            tick();
        end
        rand_mode = 1'b0;
        wait_idle("random_drain", 1000);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
